// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 64;

    // An address is only backed by storage when it lies below the register count.
    function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset clear sequencer: walks every entry once, then holds ready high.
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          o_clr_en,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RF_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                RF_INIT: begin
                    if (r_cnt == LAST) begin
                        r_state <= RF_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RF_RUN: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_clr_en   = (r_state == RF_INIT);
    assign o_clr_addr = r_cnt;
    assign o_ready    = r_ready;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async reads, NWR sync writes, optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][AW-1:0]     ra,
    output logic [NRD-1:0][WIDTH-1:0]  rd,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][AW-1:0]     wa,
    input  logic [NWR-1:0][WIDTH-1:0]  wd,
    output logic                       ready
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_clr_en;
    logic [AW-1:0]    w_clr_addr;
    logic [NWR-1:0]   w_wr_ok;

    regfile_init_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_run)
    );

    assign ready = w_run;

    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr
            assign w_wr_ok[gi] = w_run && we[gi]
                              && rf_addr_valid(32'(wa[gi]), DEPTH)
                              && !((ZERO_REG != 0) && (wa[gi] == '0));
        end
    endgenerate

    // Ports are applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end
        for (int p = 0; p < NWR; p++) begin
            if (w_wr_ok[p]) begin
                r_mem[wa[p]] <= wd[p];
            end
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [WIDTH-1:0] w_val;
            logic             w_hit;

            assign w_hit = w_run && rf_addr_valid(32'(ra[gi]), DEPTH)
                        && !((ZERO_REG != 0) && (ra[gi] == '0));

            always_comb begin
                w_val = '0;
                if (w_hit) begin
                    w_val = r_mem[ra[gi]];
                end
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NWR; p++) begin
                    if (w_wr_ok[p] && (wa[p] == ra[gi])) begin
                        w_val = wd[p];
                    end
                end
`endif
            end

            assign rd[gi] = w_val;
        end
    endgenerate

endmodule
